// File: rtl/l2_responder_pkg.sv
// rtl/l2_responder_pkg.sv - shared bus controller types for the L2 responder
package l2_responder_pkg;

    typedef enum logic [1:0] {
        L2_FREE   = 2'd0,
        L2_BUSY   = 2'd1,
        L2_ACCESS = 2'd2,
        L2_ERROR  = 2'd3
    } l2_state_t;

    typedef logic [31:0] bus_word_t;

    // Word aligned and inside the backing store
    function automatic logic addr_legal(input bus_word_t a, input int unsigned depth);
        return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < depth);
    endfunction

endpackage

// File: rtl/l2_responder_if.sv
// rtl/l2_responder_if.sv - bus controller to L2 responder handshake bundle
interface l2_responder_if;
    import l2_responder_pkg::*;

    logic      l2REN;
    logic      l2WEN;
    bus_word_t l2addr;
    bus_word_t l2store;
    bus_word_t l2load;
    l2_state_t l2state;

    modport master (
        output l2REN, l2WEN, l2addr, l2store,
        input  l2load, l2state
    );

    modport slave (
        input  l2REN, l2WEN, l2addr, l2store,
        output l2load, l2state
    );

endinterface

// File: rtl/l2_responder_sram.sv
// rtl/l2_responder_sram.sv - DEPTH x 32 backing store, synchronous write, registered read
module l2_sram
    import l2_responder_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     CLK,
    input  logic                     wen,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  bus_word_t                wdata,
    output bus_word_t                rdata
);

    // Contents start at zero and are never touched by reset
    bus_word_t r_mem [DEPTH] = '{default: '0};

    // Write port and read-before-write registered read port
    always_ff @(posedge CLK) begin
        if (wen) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule

// File: rtl/l2_responder.sv
// rtl/l2_responder.sv - fixed-latency L2 responder FSM in front of l2_sram
module l2_responder
    import l2_responder_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 256
) (
    input  logic           CLK,
    input  logic           nRST,
    l2_responder_if.slave  bus
);

    localparam int CW = $clog2(LATENCY + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} state_t;

    state_t          r_state;
    l2_state_t       r_l2state;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_idx;
    bus_word_t       r_data;
    logic            r_write;
    bus_word_t       r_load;

    logic            w_any_req;
    logic            w_one_req;
    logic            w_legal;
    logic            w_wen;
    bus_word_t       w_rdata;

    assign w_any_req = bus.l2REN | bus.l2WEN;
    assign w_one_req = bus.l2REN ^ bus.l2WEN;
    assign w_legal   = addr_legal(bus.l2addr, DEPTH);

    // Commit happens on the edge leaving the last BUSY cycle; reset on that
    // same edge must suppress it, so the write strobe is gated by nRST.
    assign w_wen = nRST && (r_state == BUSY) && (r_cnt == '0) && w_any_req && r_write;

    l2_sram #(.DEPTH(DEPTH)) u_sram (
        .CLK   (CLK),
        .wen   (w_wen),
        .addr  (r_idx),
        .wdata (r_data),
        .rdata (w_rdata)
    );

    // Sequencer: accept, count down LATENCY busy cycles, access, or error/abort
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state   <= FREE;
            r_l2state <= L2_FREE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_data    <= '0;
            r_write   <= 1'b0;
            r_load    <= '0;
        end else begin
            case (r_state)
                FREE: begin
                    if (w_one_req && w_legal) begin
                        r_state   <= BUSY;
                        r_l2state <= L2_BUSY;
                        r_cnt     <= CW'(LATENCY - 1);
                        r_idx     <= bus.l2addr[AW+1:2];
                        r_data    <= bus.l2store;
                        r_write   <= bus.l2WEN;
                    end else if (w_any_req) begin
                        r_state   <= ERROR;
                        r_l2state <= L2_ERROR;
                    end
                end
                BUSY: begin
                    if (!w_any_req) begin
                        r_state   <= FREE;
                        r_l2state <= L2_FREE;
                    end else if (r_cnt == '0) begin
                        r_state   <= ACCESS;
                        r_l2state <= L2_ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ACCESS: begin
                    // Keep the read value so l2load holds it after ACCESS
                    if (!r_write) begin
                        r_load <= w_rdata;
                    end
                    r_state   <= FREE;
                    r_l2state <= L2_FREE;
                end
                default: begin
                    r_state   <= FREE;
                    r_l2state <= L2_FREE;
                end
            endcase
        end
    end

    // During a read ACCESS the SRAM register already holds the fresh word
    assign bus.l2load  = ((r_state == ACCESS) && !r_write) ? w_rdata : r_load;
    assign bus.l2state = r_l2state;

endmodule
